// File: rtl/fir_seq_pkg.sv
// Shared state encoding, default sizing and a lane helper for the UART/FIR sample sequencer.
package fir_seq_pkg;

  typedef enum logic [2:0] {
    ST_COLLECT   = 3'd0,
    ST_FIR_START = 3'd1,
    ST_FIR_WAIT  = 3'd2,
    ST_TX_ISSUE  = 3'd3,
    ST_TX_GUARD  = 3'd4,
    ST_TX_WAIT   = 3'd5
  } seq_state_e;

  localparam int DEF_IN_BYTES     = 2;
  localparam int DEF_OUT_BYTES    = 3;
  localparam int DEF_BYTE_TIMEOUT = 50000;
  localparam int DEF_CNT_W        = 16;

  // True when lane is the final lane of a count-byte word (count is 1..4).
  function automatic logic is_last_lane(input logic [1:0] lane, input int count);
    return (lane == 2'(count - 1));
  endfunction

endpackage

// File: rtl/fir_uart_sequencer_if.sv
// Handshake bundle between the sample sequencer (master) and the UART/FIR datapath (slave).
interface fir_uart_sequencer_if
  import fir_seq_pkg::*;
#(
  parameter int IN_BYTES = DEF_IN_BYTES,
  parameter int CNT_W    = DEF_CNT_W
);
  logic                rx_data_ready;
  logic                fir_output_valid;
  logic                tx_busy;
  logic [IN_BYTES-1:0] load_in_byte;
  logic                fir_input_valid;
  logic                load_fir_out;
  logic                tx_start;
  logic [1:0]          tx_byte_sel;
  logic                overrun;
  logic                resync;
  logic [CNT_W-1:0]    sample_count;
  logic                busy;

  modport master (
    input  rx_data_ready, fir_output_valid, tx_busy,
    output load_in_byte, fir_input_valid, load_fir_out, tx_start, tx_byte_sel,
    output overrun, resync, sample_count, busy
  );

  modport slave (
    output rx_data_ready, fir_output_valid, tx_busy,
    input  load_in_byte, fir_input_valid, load_fir_out, tx_start, tx_byte_sel,
    input  overrun, resync, sample_count, busy
  );
endinterface

// File: rtl/fir_seq_byte_timer.sv
// Inter-byte idle timer: counts while enabled, pulses o_expired on the BYTE_TIMEOUT-th idle cycle.
module fir_seq_byte_timer
  import fir_seq_pkg::*;
#(
  parameter int BYTE_TIMEOUT = DEF_BYTE_TIMEOUT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int            TW   = $clog2(BYTE_TIMEOUT + 1);
  localparam logic [TW-1:0] LAST = TW'(BYTE_TIMEOUT - 1);

  logic [TW-1:0] r_count;

  // Expiry does not look at i_clear so a byte landing on the expiry cycle still sees the timeout.
  assign o_expired = i_enable & (r_count == LAST);

  // Idle-cycle counter, restarting on clear or expiry.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear | o_expired) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + TW'(1);
    end else begin
      r_count <= r_count;
    end
  end
endmodule

// File: rtl/fir_uart_sequencer.sv
// Sequences UART bytes into FIR input lanes, waits for the FIR result and streams it back out byte by byte.
module fir_uart_sequencer
  import fir_seq_pkg::*;
#(
  parameter int IN_BYTES     = DEF_IN_BYTES,
  parameter int OUT_BYTES    = DEF_OUT_BYTES,
  parameter int BYTE_TIMEOUT = DEF_BYTE_TIMEOUT,
  parameter int CNT_W        = DEF_CNT_W
) (
  input logic                  i_clk,
  input logic                  i_rst,
  fir_uart_sequencer_if.master bus
);
  seq_state_e          r_state, w_state_nx;
  logic [1:0]          r_idx, w_idx_nx, w_lane;
  logic [1:0]          r_tx_byte_sel, w_sel_nx;
  logic [IN_BYTES-1:0] r_load_in_byte, w_load_nx;
  logic                r_fir_input_valid, w_fiv_nx;
  logic                r_load_fir_out, w_lfo_nx;
  logic                r_tx_start, w_txs_nx;
  logic                r_overrun, w_ovr_nx;
  logic                r_resync, w_rsy_nx;
  logic                r_busy, w_busy_nx;
  logic [CNT_W-1:0]    r_sample_count, w_count_nx;
  logic                w_timer_en, w_timer_clr, w_expired;

  assign w_timer_en  = (r_state == ST_COLLECT) && (r_idx != 2'd0);
  assign w_timer_clr = ~w_timer_en | bus.rx_data_ready;

  fir_seq_byte_timer #(
    .BYTE_TIMEOUT(BYTE_TIMEOUT)
  ) u_byte_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (w_timer_clr),
    .i_enable (w_timer_en),
    .o_expired(w_expired)
  );

  // A byte arriving on the expiry cycle starts a fresh sample in lane 0.
  assign w_lane = w_expired ? 2'd0 : r_idx;

  // Next-state and next-output decode.
  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_sel_nx   = r_tx_byte_sel;
    w_count_nx = r_sample_count;
    w_load_nx  = '0;
    w_fiv_nx   = 1'b0;
    w_lfo_nx   = 1'b0;
    w_txs_nx   = 1'b0;
    w_ovr_nx   = r_overrun | (bus.rx_data_ready & (r_state != ST_COLLECT));
    w_rsy_nx   = r_resync | w_expired;
    case (r_state)
      ST_COLLECT: begin
        if (bus.rx_data_ready) begin
          w_load_nx = IN_BYTES'(1'b1) << w_lane;
          if (is_last_lane(w_lane, IN_BYTES)) begin
            w_idx_nx   = 2'd0;
            w_state_nx = ST_FIR_START;
          end else begin
            w_idx_nx = w_lane + 2'd1;
          end
        end else if (w_expired) begin
          w_idx_nx = 2'd0;
        end else begin
          w_idx_nx = r_idx;
        end
      end
      ST_FIR_START: begin
        w_fiv_nx   = 1'b1;
        w_state_nx = ST_FIR_WAIT;
      end
      ST_FIR_WAIT: begin
        if (bus.fir_output_valid) begin
          w_lfo_nx   = 1'b1;
          w_sel_nx   = 2'd0;
          w_state_nx = ST_TX_ISSUE;
        end else begin
          w_state_nx = ST_FIR_WAIT;
        end
      end
      ST_TX_ISSUE: begin
        if (!bus.tx_busy) begin
          w_txs_nx   = 1'b1;
          w_state_nx = ST_TX_GUARD;
        end else begin
          w_state_nx = ST_TX_ISSUE;
        end
      end
      // Transmitters may raise busy a cycle after start; skip one cycle before trusting it.
      ST_TX_GUARD: begin
        w_state_nx = ST_TX_WAIT;
      end
      ST_TX_WAIT: begin
        if (bus.tx_busy) begin
          w_state_nx = ST_TX_WAIT;
        end else if (is_last_lane(r_tx_byte_sel, OUT_BYTES)) begin
          w_count_nx = r_sample_count + CNT_W'(1);
          w_sel_nx   = 2'd0;
          w_state_nx = ST_COLLECT;
        end else begin
          w_sel_nx   = r_tx_byte_sel + 2'd1;
          w_state_nx = ST_TX_ISSUE;
        end
      end
      default: begin
        w_state_nx = ST_COLLECT;
        w_idx_nx   = 2'd0;
        w_sel_nx   = 2'd0;
      end
    endcase
    w_busy_nx = (w_state_nx != ST_COLLECT) || (w_idx_nx != 2'd0);
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state           <= ST_COLLECT;
      r_idx             <= 2'd0;
      r_tx_byte_sel     <= 2'd0;
      r_sample_count    <= '0;
      r_load_in_byte    <= '0;
      r_fir_input_valid <= 1'b0;
      r_load_fir_out    <= 1'b0;
      r_tx_start        <= 1'b0;
      r_overrun         <= 1'b0;
      r_resync          <= 1'b0;
      r_busy            <= 1'b0;
    end else begin
      r_state           <= w_state_nx;
      r_idx             <= w_idx_nx;
      r_tx_byte_sel     <= w_sel_nx;
      r_sample_count    <= w_count_nx;
      r_load_in_byte    <= w_load_nx;
      r_fir_input_valid <= w_fiv_nx;
      r_load_fir_out    <= w_lfo_nx;
      r_tx_start        <= w_txs_nx;
      r_overrun         <= w_ovr_nx;
      r_resync          <= w_rsy_nx;
      r_busy            <= w_busy_nx;
    end
  end

  assign bus.load_in_byte    = r_load_in_byte;
  assign bus.fir_input_valid = r_fir_input_valid;
  assign bus.load_fir_out    = r_load_fir_out;
  assign bus.tx_start        = r_tx_start;
  assign bus.tx_byte_sel     = r_tx_byte_sel;
  assign bus.overrun         = r_overrun;
  assign bus.resync          = r_resync;
  assign bus.sample_count    = r_sample_count;
  assign bus.busy            = r_busy;
endmodule

// File: tb/tb_fir_uart_sequencer.sv
// Directed bench: cycle table for the fast path, then sequences for timeout, overrun, stall, reset and wrap.
module tb_fir_uart_sequencer;
  localparam int TB_TIMEOUT = 120;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fir_uart_sequencer_if #(.IN_BYTES(2), .CNT_W(2)) bus ();

  fir_uart_sequencer #(
    .IN_BYTES(2), .OUT_BYTES(3), .BYTE_TIMEOUT(TB_TIMEOUT), .CNT_W(2)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int   errors = 0;
  int   checks = 0;
  logic tb_rx = 1'b0, tb_fov = 1'b0, tb_busy = 1'b0, model_en = 1'b0;
  logic m_fov = 1'b0;
  int   m_cnt = 0, fir_dly = 0, fiv_n = 0, lfo_n = 0;
  logic [1:0] load_log[$];
  logic [1:0] sel_log[$];

  assign bus.rx_data_ready    = tb_rx;
  assign bus.fir_output_valid = tb_fov | m_fov;
  assign bus.tx_busy          = tb_busy | (m_cnt != 0);

  // Event log plus FIR (20-cycle latency) and transmitter (10 busy cycles per start) responders.
  always @(negedge clk) begin
    if (bus.load_in_byte != 2'b00) load_log.push_back(bus.load_in_byte);
    if (bus.tx_start) sel_log.push_back(bus.tx_byte_sel);
    if (bus.fir_input_valid) fiv_n <= fiv_n + 1;
    if (bus.load_fir_out) lfo_n <= lfo_n + 1;
    if (rst || !model_en) begin
      m_cnt <= 0; m_fov <= 1'b0; fir_dly <= 0;
    end else begin
      m_fov <= 1'b0;
      if (bus.tx_start) m_cnt <= 10;
      else if (m_cnt != 0) m_cnt <= m_cnt - 1;
      if (bus.fir_input_valid) fir_dly <= 20;
      else if (fir_dly != 0) begin
        fir_dly <= fir_dly - 1;
        if (fir_dly == 1) m_fov <= 1'b1;
      end
    end
  end

  typedef struct {
    logic        rx;
    logic        fov;
    logic        bsy;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(input logic rx, input logic fov, input logic bsy,
                              input logic [1:0] ld, input logic fiv, input logic lfo,
                              input logic txs, input logic [1:0] sel, input logic bo,
                              input logic [1:0] cnt, input logic ovr, input logic rsy);
    vec_t v;
    v.rx = rx; v.fov = fov; v.bsy = bsy;
    v.exp = {ld, fiv, lfo, txs, sel, bo, cnt, ovr, rsy};
    return v;
  endfunction

  function automatic logic [11:0] snap();
    return {bus.load_in_byte, bus.fir_input_valid, bus.load_fir_out, bus.tx_start,
            bus.tx_byte_sel, bus.busy, bus.sample_count, bus.overrun, bus.resync};
  endfunction

  function automatic logic [3:0] lanes2(input int s);
    if (load_log.size() < s + 2) return 4'hF;
    return {load_log[s], load_log[s+1]};
  endfunction

  function automatic logic [5:0] sels3(input int s);
    if (sel_log.size() < s + 3) return 6'h3F;
    return {sel_log[s], sel_log[s+1], sel_log[s+2]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input string name);
    tb_rx = 1'b0; tb_fov = 1'b0; tb_busy = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check(name, 32'(snap()), 32'h0);
    rst = 1'b0;
  endtask

  task automatic pulse_rx();
    tb_rx = 1'b1;
    @(negedge clk);
    tb_rx = 1'b0;
  endtask

  task automatic send_sample(input int gap);
    pulse_rx();
    repeat (gap - 1) @(negedge clk);
    pulse_rx();
  endtask

  task automatic wait_starts(input string name, input int n);
    int seen = 0;
    for (int i = 0; i < 600 && seen < n; i++) begin
      @(negedge clk);
      if (bus.tx_start) seen++;
    end
    check(name, 32'(seen), 32'(n));
  endtask

  task automatic wait_count(input string name, input logic [1:0] exp);
    logic [1:0] prev = bus.sample_count;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.sample_count != prev) break;
    end
    check(name, 32'(bus.sample_count), 32'(exp));
  endtask

  initial begin
    int lb, sb, fb, ob;
    //            rx fov bsy  ld    fiv lfo txs sel   bo cnt   ovr rsy
    tbl[0]  = mk(0, 0, 0, 2'b00, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 2'b01, 0, 0, 0, 2'd0, 1, 2'd0, 0, 0);
    tbl[2]  = mk(1, 0, 0, 2'b10, 0, 0, 0, 2'd0, 1, 2'd0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 2'b00, 1, 0, 0, 2'd0, 1, 2'd0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 2'b00, 0, 0, 0, 2'd0, 1, 2'd0, 0, 0);
    tbl[5]  = mk(0, 1, 0, 2'b00, 0, 1, 0, 2'd0, 1, 2'd0, 0, 0);
    tbl[6]  = mk(0, 0, 1, 2'b00, 0, 0, 0, 2'd0, 1, 2'd0, 0, 0);
    tbl[7]  = mk(0, 0, 0, 2'b00, 0, 0, 1, 2'd0, 1, 2'd0, 0, 0);
    tbl[8]  = mk(0, 0, 1, 2'b00, 0, 0, 0, 2'd0, 1, 2'd0, 0, 0);
    tbl[9]  = mk(0, 0, 1, 2'b00, 0, 0, 0, 2'd0, 1, 2'd0, 0, 0);
    tbl[10] = mk(0, 0, 0, 2'b00, 0, 0, 0, 2'd1, 1, 2'd0, 0, 0);
    tbl[11] = mk(0, 0, 0, 2'b00, 0, 0, 1, 2'd1, 1, 2'd0, 0, 0);
    tbl[12] = mk(0, 0, 0, 2'b00, 0, 0, 0, 2'd1, 1, 2'd0, 0, 0);
    tbl[13] = mk(0, 0, 0, 2'b00, 0, 0, 0, 2'd2, 1, 2'd0, 0, 0);
    tbl[14] = mk(0, 0, 0, 2'b00, 0, 0, 1, 2'd2, 1, 2'd0, 0, 0);
    tbl[15] = mk(0, 0, 0, 2'b00, 0, 0, 0, 2'd2, 1, 2'd0, 0, 0);
    tbl[16] = mk(0, 0, 0, 2'b00, 0, 0, 0, 2'd0, 0, 2'd1, 0, 0);
    tbl[17] = mk(1, 0, 0, 2'b01, 0, 0, 0, 2'd0, 1, 2'd1, 0, 0);
    tbl[18] = mk(0, 1, 0, 2'b00, 0, 0, 0, 2'd0, 1, 2'd1, 0, 0);

    do_reset("reset_state");
    for (int i = 0; i < 19; i++) begin
      tb_rx = tbl[i].rx; tb_fov = tbl[i].fov; tb_busy = tbl[i].bsy;
      @(negedge clk);
      check($sformatf("vec%0d", i), 32'(snap()), 32'(tbl[i].exp));
    end

    // Nominal: bytes 100 cycles apart, responders active.
    do_reset("nom_reset");
    model_en = 1'b1;
    lb = load_log.size(); sb = sel_log.size(); fb = fiv_n; ob = lfo_n;
    send_sample(100);
    wait_count("nom_count", 2'd1);
    check("nom_lanes", 32'(lanes2(lb)), 32'h6);
    check("nom_fiv", 32'(fiv_n - fb), 32'd1);
    check("nom_lfo", 32'(lfo_n - ob), 32'd1);
    check("nom_sels", 32'(sels3(sb)), 32'b00_01_10);

    // Timeout: lone byte, long idle, then a full sample.
    do_reset("to_reset");
    lb = load_log.size(); fb = fiv_n;
    pulse_rx();
    repeat (TB_TIMEOUT + 30) @(negedge clk);
    check("to_resync", 32'(bus.resync), 32'd1);
    check("to_idle", 32'(bus.busy), 32'd0);
    send_sample(3);
    wait_count("to_count", 2'd1);
    check("to_nloads", 32'(load_log.size() - lb), 32'd3);
    check("to_lanes", 32'(lanes2(lb + 1)), 32'h6);
    check("to_fiv", 32'(fiv_n - fb), 32'd1);
    check("to_sticky", 32'(bus.resync), 32'd1);

    // Gap one short of the timeout keeps the partial sample.
    do_reset("lo_reset");
    send_sample(TB_TIMEOUT - 1);
    check("lo_lane1", 32'(bus.load_in_byte), 32'h2);
    check("lo_noresync", 32'(bus.resync), 32'd0);
    wait_count("lo_count", 2'd1);

    // Byte on the expiry cycle becomes lane 0 of a new sample.
    do_reset("eq_reset");
    send_sample(TB_TIMEOUT);
    check("eq_lane0", 32'(bus.load_in_byte), 32'h1);
    check("eq_resync", 32'(bus.resync), 32'd1);
    check("eq_busy", 32'(bus.busy), 32'd1);
    pulse_rx();
    wait_count("eq_count", 2'd1);

    // Overrun during FIR_WAIT and TX_WAIT.
    do_reset("ov_reset");
    lb = load_log.size(); sb = sel_log.size(); fb = fiv_n;
    send_sample(5);
    repeat (3) @(negedge clk);
    pulse_rx();
    check("ov_set", 32'(bus.overrun), 32'd1);
    check("ov_noload", 32'(bus.load_in_byte), 32'd0);
    wait_starts("ov_start", 1);
    repeat (3) @(negedge clk);
    pulse_rx();
    wait_count("ov_count", 2'd1);
    check("ov_nloads", 32'(load_log.size() - lb), 32'd2);
    check("ov_fiv", 32'(fiv_n - fb), 32'd1);
    check("ov_sels", 32'(sels3(sb)), 32'b00_01_10);
    check("ov_sticky", 32'(bus.overrun), 32'd1);

    // Transmitter busy from before the first byte for 200 cycles.
    do_reset("st_reset");
    tb_busy = 1'b1;
    sb = sel_log.size();
    send_sample(5);
    repeat (194) @(negedge clk);
    check("st_held", 32'(sel_log.size() - sb), 32'd0);
    check("st_busy", 32'(bus.busy), 32'd1);
    tb_busy = 1'b0;
    @(negedge clk);
    check("st_start", 32'(bus.tx_start), 32'd1);
    check("st_sel0", 32'(bus.tx_byte_sel), 32'd0);
    wait_count("st_count", 2'd1);

    // Reset right after the second tx_start.
    do_reset("rt_reset");
    send_sample(4);
    wait_starts("rt_two_starts", 2);
    do_reset("rt_abort");
    sb = sel_log.size(); lb = load_log.size();
    repeat (30) @(negedge clk);
    check("rt_no_start", 32'(sel_log.size() - sb), 32'd0);
    send_sample(4);
    wait_count("rt_count", 2'd1);
    check("rt_lanes", 32'(lanes2(lb)), 32'h6);

    // Counter wrap with a 2-bit sample_count.
    do_reset("wr_reset");
    for (int k = 0; k < 5; k++) begin
      send_sample(3);
      wait_count($sformatf("wrap%0d", k), 2'(k + 1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
